// File: rtl/md_pad_pkg.sv
// rtl/md_pad_pkg.sv - shared constants and FSM state type for the Mega Drive pad scanner
package md_pad_pkg;

    localparam int JOY_W = 12;
    localparam int PIN_W = 6;

    // Bit positions in the published active-high button word
    localparam int BIT_R     = 0;
    localparam int BIT_L     = 1;
    localparam int BIT_D     = 2;
    localparam int BIT_U     = 3;
    localparam int BIT_B     = 4;
    localparam int BIT_C     = 5;
    localparam int BIT_A     = 6;
    localparam int BIT_START = 7;
    localparam int BIT_MODE  = 8;
    localparam int BIT_X     = 9;
    localparam int BIT_Y     = 10;
    localparam int BIT_Z     = 11;

    // Physical pin positions on joy_in; meaning depends on the SELECT phase
    localparam int PIN_RIGHT_MODE = 0;
    localparam int PIN_LEFT_X     = 1;
    localparam int PIN_DOWN_Y     = 2;
    localparam int PIN_UP_Z       = 3;
    localparam int PIN_B_A        = 4;
    localparam int PIN_C_START    = 5;

    typedef enum logic {
        ST_GAP   = 1'b0,
        ST_PHASE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/md_pad_sync.sv
// rtl/md_pad_sync.sv - two-flop synchronizer with a configurable reset value
module md_pad_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/md_pad_scanner.sv
// rtl/md_pad_scanner.sv - scans two Mega Drive 3/6-button pads and publishes per-port button words
module md_pad_scanner
    import md_pad_pkg::*;
#(
    parameter int PHASE_CYCLES = 400,
    parameter int GAP_CYCLES   = 60000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [PIN_W-1:0]  joy_in,
    output logic              joy_mdsel,
    output logic              joy_split,
    output logic [JOY_W-1:0]  joystick1,
    output logic [JOY_W-1:0]  joystick2,
    output logic              present1,
    output logic              present2,
    output logic              six_btn1,
    output logic              six_btn2
);

    localparam int CNT_MAX = (GAP_CYCLES > PHASE_CYCLES) ? GAP_CYCLES : PHASE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);

    logic [PIN_W-1:0] pins_sync;
    logic [PIN_W-1:0] pad_s;

    scan_state_e      state_q,  state_d;
    logic             port_q,   port_d;
    logic [2:0]       phase_q,  phase_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [JOY_W-1:0] shadow_q, shadow_d;
    logic             md_q,     md_d;
    logic             six_q,    six_d;
    logic [JOY_W-1:0] joy1_q,   joy1_d;
    logic [JOY_W-1:0] joy2_q,   joy2_d;
    logic             pres1_q,  pres1_d;
    logic             pres2_q,  pres2_d;
    logic             six1_q,   six1_d;
    logic             six2_q,   six2_d;
    logic [JOY_W-1:0] commit_word;

    // Pins idle high, so "released" is all ones on the raw side
    md_pad_sync #(
        .WIDTH     (PIN_W),
        .RESET_VAL ({PIN_W{1'b1}})
    ) u_sync (
        .clk_i    (clk_sys),
        .resetn_i (reset_n),
        .d_i      (joy_in),
        .q_o      (pins_sync)
    );

    assign pad_s = ~pins_sync;

    always_comb begin
        commit_word = shadow_q;
        if (!md_q) begin
            commit_word[JOY_W-1:BIT_A] = '0;
        end
        if (!six_q) begin
            commit_word[JOY_W-1:BIT_MODE] = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        md_d     = md_q;
        six_d    = six_q;
        joy1_d   = joy1_q;
        joy2_d   = joy2_q;
        pres1_d  = pres1_q;
        pres2_d  = pres2_q;
        six1_d   = six1_q;
        six2_d   = six2_q;

        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    phase_d = 3'd0;
                    state_d = ST_PHASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PHASE: begin
                if (cnt_q == PHASE_LAST) begin
                    cnt_d   = '0;
                    phase_d = phase_q + 3'd1;
                    case (phase_q)
                        3'd0: begin
                            shadow_d        = '0;
                            shadow_d[BIT_R] = pad_s[PIN_RIGHT_MODE];
                            shadow_d[BIT_L] = pad_s[PIN_LEFT_X];
                            shadow_d[BIT_D] = pad_s[PIN_DOWN_Y];
                            shadow_d[BIT_U] = pad_s[PIN_UP_Z];
                            shadow_d[BIT_B] = pad_s[PIN_B_A];
                            shadow_d[BIT_C] = pad_s[PIN_C_START];
                            md_d            = 1'b0;
                            six_d           = 1'b0;
                        end
                        3'd1: begin
                            md_d = pad_s[PIN_LEFT_X] & pad_s[PIN_RIGHT_MODE];
                            if (pad_s[PIN_LEFT_X] & pad_s[PIN_RIGHT_MODE]) begin
                                shadow_d[BIT_A]     = pad_s[PIN_B_A];
                                shadow_d[BIT_START] = pad_s[PIN_C_START];
                            end
                        end
                        3'd5: begin
                            six_d = &pad_s[PIN_UP_Z:PIN_RIGHT_MODE];
                        end
                        3'd6: begin
                            if (six_q) begin
                                shadow_d[BIT_MODE] = pad_s[PIN_RIGHT_MODE];
                                shadow_d[BIT_X]    = pad_s[PIN_LEFT_X];
                                shadow_d[BIT_Y]    = pad_s[PIN_DOWN_Y];
                                shadow_d[BIT_Z]    = pad_s[PIN_UP_Z];
                            end
                        end
                        3'd7: begin
                            // Single-cycle transfer so a port never shows a partial scan
                            if (!port_q) begin
                                joy1_d  = commit_word;
                                pres1_d = md_q;
                                six1_d  = six_q;
                            end else begin
                                joy2_d  = commit_word;
                                pres2_d = md_q;
                                six2_d  = six_q;
                            end
                            port_d  = ~port_q;
                            phase_d = 3'd0;
                            state_d = ST_GAP;
                        end
                        default: begin
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= ST_GAP;
            port_q   <= 1'b0;
            phase_q  <= 3'd0;
            cnt_q    <= '0;
            shadow_q <= '0;
            md_q     <= 1'b0;
            six_q    <= 1'b0;
            joy1_q   <= '0;
            joy2_q   <= '0;
            pres1_q  <= 1'b0;
            pres2_q  <= 1'b0;
            six1_q   <= 1'b0;
            six2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            md_q     <= md_d;
            six_q    <= six_d;
            joy1_q   <= joy1_d;
            joy2_q   <= joy2_d;
            pres1_q  <= pres1_d;
            pres2_q  <= pres2_d;
            six1_q   <= six1_d;
            six2_q   <= six2_d;
        end
    end

    // SELECT idles high in the gap so the external port mux switches cleanly
    assign joy_mdsel = (state_q == ST_GAP) ? 1'b1 : ~phase_q[0];
    assign joy_split = port_q;
    assign joystick1 = joy1_q;
    assign joystick2 = joy2_q;
    assign present1  = pres1_q;
    assign present2  = pres2_q;
    assign six_btn1  = six1_q;
    assign six_btn2  = six2_q;

endmodule

// File: tb/tb_md_pad_scanner.sv
// tb/tb_md_pad_scanner.sv - self-checking bench for md_pad_scanner with a behavioural pad model
module tb_md_pad_scanner;

    localparam int PH   = 10;
    localparam int GP   = 40;
    localparam int SCAN = GP + 8 * PH;

    typedef enum int {PAD_NONE, PAD_3B, PAD_6B} pad_kind_e;

    typedef struct {
        pad_kind_e   k1;
        logic [11:0] b1;
        logic [5:0]  r1;
        pad_kind_e   k2;
        logic [11:0] b2;
        logic [5:0]  r2;
        logic [11:0] e_j1;
        logic        e_p1;
        logic        e_s1;
        logic [11:0] e_j2;
        logic        e_p2;
        logic        e_s2;
    } vec_t;

    typedef struct {
        logic [11:0] j1;
        logic        p1;
        logic        s1;
        logic [11:0] j2;
        logic        p2;
        logic        s2;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  joy_in;
    logic        joy_mdsel, joy_split;
    logic [11:0] joystick1, joystick2;
    logic        present1, present2, six_btn1, six_btn2;

    int errors = 0;
    int checks = 0;

    pad_kind_e   kind1 = PAD_NONE, kind2 = PAD_NONE;
    logic [11:0] btn1 = '0, btn2 = '0;
    logic [5:0]  raw1 = 6'h00, raw2 = 6'h3F;

    md_pad_scanner #(
        .PHASE_CYCLES (PH),
        .GAP_CYCLES   (GP)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .joy_in    (joy_in),
        .joy_mdsel (joy_mdsel),
        .joy_split (joy_split),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .present1  (present1),
        .present2  (present2),
        .six_btn1  (six_btn1),
        .six_btn2  (six_btn2)
    );

    always #5 clk_sys = ~clk_sys;

    // Pad model: counts SELECT falls, resets its counter after a long SELECT-high idle
    int   lows = 0;
    int   hi_cnt = 0;
    logic prev_sel = 1'b1;
    int   cur_phase;

    always @(posedge clk_sys) begin
        prev_sel <= joy_mdsel;
        if (joy_mdsel !== 1'b0) begin
            hi_cnt <= hi_cnt + 1;
            if (hi_cnt >= 15) lows <= 0;
        end else begin
            hi_cnt <= 0;
            if (prev_sel) lows <= lows + 1;
        end
    end

    function automatic logic [5:0] pad_pins(pad_kind_e k, logic [11:0] b, logic [5:0] raw, int ph);
        logic [5:0] s;
        if (k == PAD_NONE) return raw;
        if (k == PAD_6B && ph == 5)      s = {b[7], b[6], 4'hF};
        else if (k == PAD_6B && ph == 6) s = {b[5], b[4], b[11], b[10], b[9], b[8]};
        else if (k == PAD_6B && ph == 7) s = {b[7], b[6], 4'h0};
        else if (ph % 2 == 1)            s = {b[7], b[6], b[3], b[2], 2'b11};
        else                             s = {b[5], b[4], b[3], b[2], b[1], b[0]};
        return ~s;
    endfunction

    assign cur_phase = (joy_mdsel !== 1'b0) ? 2 * lows : 2 * lows - 1;
    assign joy_in = (joy_split === 1'b1) ? pad_pins(kind2, btn2, raw2, cur_phase)
                                         : pad_pins(kind1, btn1, raw1, cur_phase);

    // Bus monitors: split must only move with SELECT high; SELECT low pulses must be PH long
    int   cyc = 0, last_toggle = -1, toggle_gap = 0, split_bad = 0;
    int   run_low = 0, low_pulses = 0, low_bad = 0;
    logic prev_split = 1'b0;

    always @(negedge clk_sys) begin
        cyc <= cyc + 1;
        prev_split <= joy_split;
        if (joy_split !== prev_split) begin
            if (joy_mdsel !== 1'b1) split_bad <= split_bad + 1;
            if (last_toggle >= 0) toggle_gap <= cyc - last_toggle;
            last_toggle <= cyc;
        end
        if (joy_mdsel === 1'b0) begin
            run_low <= run_low + 1;
        end else if (run_low != 0) begin
            low_pulses <= low_pulses + 1;
            if (run_low != PH) low_bad <= low_bad + 1;
            run_low <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_toggles(input int n);
        int   seen = 0;
        int   budget = (n + 1) * SCAN + 50;
        logic p = joy_split;
        while (seen < n && budget > 0) begin
            @(negedge clk_sys);
            budget--;
            if (joy_split !== p) begin
                seen++;
                p = joy_split;
            end
        end
        check("split_toggle_timeout", seen, n);
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_joystick1"}, joystick1, e.j1);
        check({tag, "_present1"},  present1,  e.p1);
        check({tag, "_six_btn1"},  six_btn1,  e.s1);
        check({tag, "_joystick2"}, joystick2, e.j2);
        check({tag, "_present2"},  present2,  e.p2);
        check({tag, "_six_btn2"},  six_btn2,  e.s2);
    endtask

    vec_t vecs[5];
    exp_t exp_q[$];
    exp_t e;
    exp_t zero_e;

    initial begin
        vecs[0] = '{PAD_3B,   12'h0C8, 6'h3F, PAD_NONE, 12'h000, 6'h3F,
                    12'h0C8, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[1] = '{PAD_NONE, 12'h000, 6'h37, PAD_6B,   12'h901, 6'h3F,
                    12'h008, 1'b0, 1'b0, 12'h901, 1'b1, 1'b1};
        vecs[2] = '{PAD_6B,   12'hFFF, 6'h3F, PAD_3B,   12'hF32, 6'h3F,
                    12'hFFF, 1'b1, 1'b1, 12'h032, 1'b1, 1'b0};
        vecs[3] = '{PAD_NONE, 12'h000, 6'h3F, PAD_NONE, 12'h000, 6'h3F,
                    12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[4] = '{PAD_3B,   12'h000, 6'h3F, PAD_6B,   12'h000, 6'h3F,
                    12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1};
        zero_e = '{12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};

        // Reset with all pins low, then a 3-button pad on port 1
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        check_outputs("reset", zero_e);
        check("reset_mdsel", joy_mdsel, 1'b1);
        check("reset_split", joy_split, 1'b0);
        kind1 = PAD_3B; btn1 = 12'h0C8;
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        begin
            int lp0 = low_pulses;
            repeat (SCAN - 1) @(posedge clk_sys);
            #1 check("pre_commit_joystick1", joystick1, 12'h000);
            @(posedge clk_sys);
            #1 check("first_commit_joystick1", joystick1, 12'h0C8);
            check("first_commit_present1", present1, 1'b1);
            check("first_commit_six1", six_btn1, 1'b0);
            check("first_commit_joystick2", joystick2, 12'h000);
            repeat (3) @(negedge clk_sys);
            check("select_pulses_per_scan", low_pulses - lp0, 4);
        end

        // Table-driven pad combinations
        foreach (vecs[i]) begin
            @(negedge clk_sys);
            kind1 = vecs[i].k1; btn1 = vecs[i].b1; raw1 = vecs[i].r1;
            kind2 = vecs[i].k2; btn2 = vecs[i].b2; raw2 = vecs[i].r2;
            exp_q.push_back('{vecs[i].e_j1, vecs[i].e_p1, vecs[i].e_s1,
                              vecs[i].e_j2, vecs[i].e_p2, vecs[i].e_s2});
            wait_toggles(4);
            e = exp_q.pop_front();
            check_outputs($sformatf("vec%0d", i), e);
        end
        check("split_period", toggle_gap, SCAN);

        // Reset during port 2 phase 4 with a 6-button pad
        kind1 = PAD_3B; btn1 = 12'h0C8;
        kind2 = PAD_6B; btn2 = 12'h901;
        wait_toggles(4);
        check("pre_reset_joystick2", joystick2, 12'h901);
        begin
            int budget = 4 * SCAN;
            while (!(joy_split === 1'b1 && lows == 2 && joy_mdsel === 1'b1) && budget > 0) begin
                @(negedge clk_sys);
                budget--;
            end
            check("reach_port2_phase4", budget > 0, 1'b1);
        end
        reset_n = 1'b0;
        @(posedge clk_sys);
        #1;
        check_outputs("midreset", zero_e);
        check("midreset_split", joy_split, 1'b0);
        check("midreset_mdsel", joy_mdsel, 1'b1);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (SCAN) @(posedge clk_sys);
        #1 check("after_reset_joystick1", joystick1, 12'h0C8);
        check("after_reset_joystick2_held", joystick2, 12'h000);
        repeat (SCAN - 1) @(posedge clk_sys);
        #1 check("after_reset_joystick2_pre", joystick2, 12'h000);
        @(posedge clk_sys);
        #1 check("after_reset_joystick2", joystick2, 12'h901);
        check("after_reset_six2", six_btn2, 1'b1);
        check("after_reset_present2", present2, 1'b1);

        @(negedge clk_sys);
        check("split_only_while_select_high", split_bad, 0);
        check("select_low_width", low_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
